pon_scrambler_param: RTL

PON_SCRAMBLER_PARAM -- requirements
Module: pon_scrambler_param

---
 rtl/pon_scrambler_pkg.sv | 26 ++
 rtl/lfsr_step_unrolled.sv | 53 +++++
 rtl/pon_scrambler_param.sv | 96 +++++++++
 3 files changed

// File: rtl/pon_scrambler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pon_scrambler_pkg
//  Description : Shared constants for the PON scrambler: mode encodings,
//                default feedback polynomial and default seed.
//  Revision    : 1.0 - initial release
// ============================================================================
package pon_scrambler_pkg;

    // Scrambler operating modes
    localparam int unsigned MODE_ADDITIVE   = 0;  // frame-synchronous additive
    localparam int unsigned MODE_SS_SCRAM   = 1;  // self-synchronising scrambler
    localparam int unsigned MODE_SS_DESCRAM = 2;  // self-synchronising descrambler

    // x^16 + x^8 + 1 : taps on state bits 15 and 7
    localparam logic [15:0] C_DEFAULT_POLY = 16'h8080;
    localparam logic [15:0] C_DEFAULT_SEED = 16'hDEAD;

    // True when the mode value names one of the supported modes
    function automatic bit mode_is_legal(input int unsigned mode);
        return (mode == MODE_ADDITIVE) || (mode == MODE_SS_SCRAM) ||
               (mode == MODE_SS_DESCRAM);
    endfunction

endpackage : pon_scrambler_pkg
`default_nettype wire

// File: rtl/lfsr_step_unrolled.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_step_unrolled
//  Description : Purely combinational DATA_W-step LFSR scrambler core. Bit 0
//                of the word is processed first; every step XORs the data bit
//                with the feedback bit and shifts one bit into the state.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_step_unrolled
    import pon_scrambler_pkg::*;
#(
    parameter int unsigned LFSR_W = 16,
    parameter logic [LFSR_W-1:0] POLY = LFSR_W'(C_DEFAULT_POLY),
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MODE   = MODE_ADDITIVE
) (
    input  logic [LFSR_W-1:0] i_state,
    input  logic [DATA_W-1:0] i_data,
    output logic [LFSR_W-1:0] o_state,
    output logic [DATA_W-1:0] o_data
);

    logic [LFSR_W-1:0] w_st;
    logic [DATA_W-1:0] w_out;
    logic              w_fb;
    logic              w_shift_bit;

    // Unrolled serial walk: one feedback/shift per data bit, LSB first
    always_comb begin
        w_st        = i_state;
        w_out       = '0;
        w_fb        = 1'b0;
        w_shift_bit = 1'b0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            w_fb     = ^(w_st & POLY);
            w_out[i] = i_data[i] ^ w_fb;
            // Additive mode feeds back the LFSR itself; self-sync modes feed
            // back the scrambled line bit (output when scrambling, input when
            // descrambling) so both ends converge on the same state.
            case (MODE)
                MODE_SS_SCRAM:   w_shift_bit = w_out[i];
                MODE_SS_DESCRAM: w_shift_bit = i_data[i];
                default:         w_shift_bit = w_fb;
            endcase
            w_st = {w_st[LFSR_W-2:0], w_shift_bit};
        end
    end

    assign o_state = w_st;
    assign o_data  = w_out;

endmodule : lfsr_step_unrolled
`default_nettype wire

// File: rtl/pon_scrambler_param.sv
`default_nettype none
// ============================================================================
//  Module      : pon_scrambler_param
//  Description : Parameterised PON word scrambler/descrambler with a single
//                output register, valid/ready flow control, per-word bypass
//                and start-of-frame reseeding in additive mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module pon_scrambler_param
    import pon_scrambler_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LFSR_W = 16,
    parameter logic [LFSR_W-1:0] POLY = LFSR_W'(C_DEFAULT_POLY),
    parameter logic [LFSR_W-1:0] SEED = LFSR_W'(C_DEFAULT_SEED),
    parameter int unsigned MODE   = MODE_ADDITIVE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_sof,
    output logic              s_ready,
    input  logic              cfg_bypass,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_sof,
    input  logic              m_ready
);

    // Reject unsupported configurations at elaboration
    if (!mode_is_legal(MODE)) begin : g_bad_mode
        $error("pon_scrambler_param: illegal MODE %0d", MODE);
    end
    if ((LFSR_W < 2) || (LFSR_W > 64)) begin : g_bad_lfsr_w
        $error("pon_scrambler_param: LFSR_W %0d outside 2..64", LFSR_W);
    end
    if ((DATA_W < 1) || (DATA_W > 256)) begin : g_bad_data_w
        $error("pon_scrambler_param: DATA_W %0d outside 1..256", DATA_W);
    end

    logic [LFSR_W-1:0] r_state;
    logic [DATA_W-1:0] r_m_data;
    logic              r_m_valid;
    logic              r_m_sof;

    logic              w_accept;
    logic              w_reseed;
    logic [LFSR_W-1:0] w_base_state;
    logic [LFSR_W-1:0] w_step_state;
    logic [DATA_W-1:0] w_step_data;

    // Single output register: free when empty or being drained this cycle
    assign s_ready  = !r_m_valid || m_ready;
    assign w_accept = s_valid && s_ready;

    // Only the additive mode is frame-synchronous; self-sync modes just
    // forward sof. Reseed applies even to a bypassed word.
    assign w_reseed     = s_sof && (MODE == MODE_ADDITIVE);
    assign w_base_state = w_reseed ? SEED : r_state;

    lfsr_step_unrolled #(
        .LFSR_W (LFSR_W),
        .POLY   (POLY),
        .DATA_W (DATA_W),
        .MODE   (MODE)
    ) u_step (
        .i_state (w_base_state),
        .i_data  (s_data),
        .o_state (w_step_state),
        .o_data  (w_step_data)
    );

    // LFSR state and output register advance only on an accepted word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= SEED;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_m_sof   <= 1'b0;
        end else if (w_accept) begin
            r_state   <= cfg_bypass ? w_base_state : w_step_state;
            r_m_data  <= cfg_bypass ? s_data : w_step_data;
            r_m_valid <= 1'b1;
            r_m_sof   <= s_sof;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_data  = r_m_data;
    assign m_valid = r_m_valid;
    assign m_sof   = r_m_sof;

endmodule : pon_scrambler_param
`default_nettype wire
